// File: rtl/fpu_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fpu_arbiter_if : requester, FPU and response bundle of fpu_arbiter  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface fpu_arbiter_if;
  logic        r0_valid;
  logic        r0_ready;
  logic [15:0] r0_a;
  logic [15:0] r0_b;
  logic [3:0]  r0_opcode;
  logic        r1_valid;
  logic        r1_ready;
  logic [15:0] r1_a;
  logic [15:0] r1_b;
  logic [3:0]  r1_opcode;
  logic        fpu_enable;
  logic [15:0] fpu_a;
  logic [15:0] fpu_b;
  logic [3:0]  fpu_opcode;
  logic [15:0] fpu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_result;
  logic        rsp_err;
  logic        busy;
  logic [15:0] op_count;

  modport slave (
    input  r0_valid, r0_a, r0_b, r0_opcode,
    input  r1_valid, r1_a, r1_b, r1_opcode,
    input  fpu_result, rsp_ready,
    output r0_ready, r1_ready,
    output fpu_enable, fpu_a, fpu_b, fpu_opcode,
    output rsp_valid, rsp_id, rsp_result, rsp_err, busy, op_count
  );

  modport master (
    output r0_valid, r0_a, r0_b, r0_opcode,
    output r1_valid, r1_a, r1_b, r1_opcode,
    output fpu_result, rsp_ready,
    input  r0_ready, r1_ready,
    input  fpu_enable, fpu_a, fpu_b, fpu_opcode,
    input  rsp_valid, rsp_id, rsp_result, rsp_err, busy, op_count
  );
endinterface
`default_nettype wire

// File: rtl/fpu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fpu_arbiter : round-robin share of one half-precision FPU           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fpu_arbiter #(
  parameter int LAT     = 2,
  parameter int NUM_OPS = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fpu_arbiter_if.slave bus
);
  localparam logic [1:0]  c_idle    = 2'd0;
  localparam logic [1:0]  c_busy    = 2'd1;
  localparam logic [1:0]  c_resp    = 2'd2;
  localparam logic [3:0]  c_lat_m1  = 4'(LAT - 1);
  localparam logic [4:0]  c_num_ops = 5'(NUM_OPS);
  localparam logic [15:0] c_qnan    = 16'h7E00;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic        r_last_grant;
  logic        r_id;
  logic        r_rsp_err;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [3:0]  r_opcode;
  logic [3:0]  r_cnt;
  logic [15:0] r_rsp_result;
  logic [15:0] r_op_count;

  logic        w_grant;
  logic        w_hs;
  logic        w_legal;
  logic        w_rsp_hs;
  logic [15:0] w_req_a;
  logic [15:0] w_req_b;
  logic [3:0]  w_req_opcode;

  // A lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    if (bus.r0_valid && bus.r1_valid) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = bus.r1_valid;
    end
    w_hs         = (r_state == c_idle) && (w_grant ? bus.r1_valid : bus.r0_valid);
    w_req_a      = w_grant ? bus.r1_a      : bus.r0_a;
    w_req_b      = w_grant ? bus.r1_b      : bus.r0_b;
    w_req_opcode = w_grant ? bus.r1_opcode : bus.r0_opcode;
    w_legal      = ({1'b0, w_req_opcode} < c_num_ops);
    w_rsp_hs     = (r_state == c_resp) && bus.rsp_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle: if (w_hs) w_next_state = w_legal ? c_busy : c_resp;
      c_busy: if (r_cnt == 4'd0) w_next_state = c_resp;
      c_resp: if (bus.rsp_ready) w_next_state = c_idle;
      default: w_next_state = c_idle;
    endcase
  end

  // Operands are isolated to zero outside BUSY so the FPU inputs stay quiet.
  always_comb begin
    bus.fpu_enable = 1'b0;
    bus.fpu_a      = 16'd0;
    bus.fpu_b      = 16'd0;
    bus.fpu_opcode = 4'd0;
    if (r_state == c_busy) begin
      bus.fpu_enable = 1'b1;
      bus.fpu_a      = r_a;
      bus.fpu_b      = r_b;
      bus.fpu_opcode = r_opcode;
    end
    bus.r0_ready   = w_hs && !w_grant;
    bus.r1_ready   = w_hs && w_grant;
    bus.rsp_valid  = (r_state == c_resp);
    bus.busy       = (r_state != c_idle);
    bus.rsp_id     = r_id;
    bus.rsp_result = r_rsp_result;
    bus.rsp_err    = r_rsp_err;
    bus.op_count   = r_op_count;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_a          <= 16'd0;
      r_b          <= 16'd0;
      r_opcode     <= 4'd0;
      r_cnt        <= 4'd0;
      r_rsp_result <= 16'd0;
      r_rsp_err    <= 1'b0;
      r_op_count   <= 16'd0;
    end else begin
      if (w_hs) begin
        r_a          <= w_req_a;
        r_b          <= w_req_b;
        r_opcode     <= w_req_opcode;
        r_id         <= w_grant;
        r_last_grant <= w_grant;
        r_cnt        <= c_lat_m1;
        if (!w_legal) begin
          r_rsp_result <= c_qnan;
          r_rsp_err    <= 1'b1;
        end
      end
      if (r_state == c_busy) begin
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd0) begin
          r_rsp_result <= bus.fpu_result;
          r_rsp_err    <= 1'b0;
        end
      end
      if (w_rsp_hs) begin
        r_op_count <= r_op_count + 16'd1;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fpu_arbiter.sv
`default_nettype none
// Bench for fpu_arbiter: directed scenarios, then random traffic against a
// timing-rule reference model; the FPU is a behavioural half-precision model.
module tb_fpu_arbiter;
  localparam int LAT     = 2;
  localparam int NUM_OPS = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  fpu_arbiter_if bus ();

  fpu_arbiter #(.LAT(LAT), .NUM_OPS(NUM_OPS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic real h2r(input logic [15:0] h);
    real v;
    int  e;
    if (h[14:10] == 5'd0) return 0.0;
    v = 1.0 + real'(h[9:0]) / 1024.0;
    e = int'(h[14:10]) - 15;
    for (int i = 0; i < 32; i++) begin
      if (e > 0) begin v = v * 2.0; e--; end
      else if (e < 0) begin v = v / 2.0; e++; end
    end
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real x);
    real  v;
    int   e;
    logic s;
    s = (x < 0.0);
    v = s ? -x : x;
    if (v == 0.0) return 16'h0000;
    e = 15;
    for (int i = 0; i < 64; i++) begin
      if (v >= 2.0) begin v = v / 2.0; e++; end
      else if (v < 1.0) begin v = v * 2.0; e--; end
    end
    if (e < 1)  return {s, 15'd0};
    if (e > 30) return {s, 5'h1F, 10'd0};
    return {s, 5'(e), 10'($rtoi((v - 1.0) * 1024.0))};
  endfunction

  function automatic logic [15:0] fpu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] op);
    if (op == 4'd0) return r2h(h2r(a) + h2r(b));
    if (op == 4'd1) return r2h(h2r(a) * h2r(b));
    return 16'h0000;
  endfunction

  assign bus.fpu_result = fpu_model(bus.fpu_a, bus.fpu_b, bus.fpu_opcode);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.r0_valid = 1'b0; bus.r0_a = '0; bus.r0_b = '0; bus.r0_opcode = '0;
    bus.r1_valid = 1'b0; bus.r1_a = '0; bus.r1_b = '0; bus.r1_opcode = '0;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (!bus.busy) done = 1'b1;
      else tick();
    end
    chk(tag, 32'(done), 1);
    tick();
  endtask

  task automatic wait_ready(output logic id, output logic ok);
    ok = 1'b0;
    id = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (bus.r0_ready || bus.r1_ready) begin
        ok = 1'b1;
        id = bus.r1_ready;
      end else begin
        tick();
      end
    end
  endtask

  task automatic wait_rsp(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (bus.rsp_valid) ok = 1'b1;
      else tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference-model state for the random phase
  logic        pend [2];
  logic [15:0] pa [2];
  logic [15:0] pb [2];
  logic [3:0]  pop [2];
  logic        m_last, m_out, m_legal, m_id, m_err;
  logic [15:0] m_res, m_a, m_b, m_count;
  logic [3:0]  m_op;
  int          m_t_acc;

  initial begin
    logic ok, id, eg, eacc, erv, een;
    int   age;
    clear_inputs();
    rst_n = 1'b0;
    tick();
    #1;
    chk("reset_busy",      32'(bus.busy),       0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid),  0);
    chk("reset_fpu_en",    32'(bus.fpu_enable), 0);
    chk("reset_fpu_a",     32'(bus.fpu_a),      0);
    chk("reset_op_count",  32'(bus.op_count),   0);
    chk("reset_rsp_res",   32'(bus.rsp_result), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single add: 1.0 + 2.0
    bus.r0_valid = 1'b1; bus.r0_a = 16'h3C00; bus.r0_b = 16'h4000; bus.r0_opcode = 4'd0;
    bus.rsp_ready = 1'b1;
    #1;
    chk("single_r0_ready", 32'(bus.r0_ready),   1);
    chk("single_r1_ready", 32'(bus.r1_ready),   0);
    chk("single_en_t0",    32'(bus.fpu_enable), 0);
    tick();
    bus.r0_valid = 1'b0;
    #1;
    chk("single_en_t1",  32'(bus.fpu_enable), 1);
    chk("single_fpu_a",  32'(bus.fpu_a),      'h3C00);
    chk("single_fpu_b",  32'(bus.fpu_b),      'h4000);
    chk("single_busy",   32'(bus.busy),       1);
    tick(); #1;
    chk("single_en_t2",  32'(bus.fpu_enable), 1);
    chk("single_rv_t2",  32'(bus.rsp_valid),  0);
    tick(); #1;
    chk("single_rv_t3",  32'(bus.rsp_valid),  1);
    chk("single_id",     32'(bus.rsp_id),     0);
    chk("single_result", 32'(bus.rsp_result), 'h4200);
    chk("single_err",    32'(bus.rsp_err),    0);
    chk("single_en_t3",  32'(bus.fpu_enable), 0);
    chk("single_iso_a",  32'(bus.fpu_a),      0);
    tick(); #1;
    chk("single_rv_t4",  32'(bus.rsp_valid),  0);
    chk("single_count",  32'(bus.op_count),   1);
    tick();

    // Illegal opcode on requester 1
    bus.r1_valid = 1'b1; bus.r1_a = 16'h1234; bus.r1_b = 16'h5678; bus.r1_opcode = 4'h7;
    bus.rsp_ready = 1'b0;
    #1;
    chk("illegal_r1_ready", 32'(bus.r1_ready), 1);
    tick();
    bus.r1_valid = 1'b0;
    #1;
    chk("illegal_en",     32'(bus.fpu_enable), 0);
    chk("illegal_rv",     32'(bus.rsp_valid),  1);
    chk("illegal_err",    32'(bus.rsp_err),    1);
    chk("illegal_result", 32'(bus.rsp_result), 'h7E00);
    chk("illegal_id",     32'(bus.rsp_id),     1);
    bus.rsp_ready = 1'b1;
    tick(); #1;
    chk("illegal_count",  32'(bus.op_count),   2);
    tick();

    // Backpressure: 2.0 * 3.0 held in RESP while r0 waits
    bus.r0_valid = 1'b1; bus.r0_a = 16'h4000; bus.r0_b = 16'h4200; bus.r0_opcode = 4'd1;
    bus.rsp_ready = 1'b0;
    #1;
    chk("bp_accept", 32'(bus.r0_ready), 1);
    tick();
    bus.r0_valid = 1'b0;
    tick();
    tick();
    bus.r0_valid = 1'b1; bus.r0_a = 16'h3C00; bus.r0_b = 16'h3C00; bus.r0_opcode = 4'd0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rv",     32'(bus.rsp_valid),  1);
      chk("bp_result", 32'(bus.rsp_result), 'h4600);
      chk("bp_id",     32'(bus.rsp_id),     0);
      chk("bp_ready",  32'(bus.r0_ready),   0);
      chk("bp_en",     32'(bus.fpu_enable), 0);
      chk("bp_iso",    32'({bus.fpu_a, bus.fpu_b}), 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_hs_rv",    32'(bus.rsp_valid), 1);
    chk("bp_hs_ready", 32'(bus.r0_ready),  0);
    tick(); #1;
    chk("bp_next_grant", 32'(bus.r0_ready), 1);
    tick();
    bus.r0_valid = 1'b0;
    drain("bp_drain");

    // Round-robin after reset: both valid, multiply
    do_reset();
    bus.r0_valid = 1'b1; bus.r0_a = 16'h3C00; bus.r0_b = 16'h4000; bus.r0_opcode = 4'd1;
    bus.r1_valid = 1'b1; bus.r1_a = 16'h4000; bus.r1_b = 16'h4000; bus.r1_opcode = 4'd1;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ready(id, ok);
      chk("rr_ready_seen", 32'(ok), 1);
      chk("rr_grant",      32'(id), 32'(k % 2));
      chk("rr_one_ready",  32'(bus.r0_ready & bus.r1_ready), 0);
      tick();
      wait_rsp(ok);
      chk("rr_rsp_seen", 32'(ok), 1);
      chk("rr_rsp_id",   32'(bus.rsp_id), 32'(k % 2));
      chk("rr_result",   32'(bus.rsp_result), (k % 2 == 1) ? 'h4400 : 'h4000);
      tick();
    end
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    drain("rr_drain");

    // Async reset while BUSY
    bus.r0_valid = 1'b1; bus.r0_a = 16'h4400; bus.r0_b = 16'h3C00; bus.r0_opcode = 4'd0;
    #1;
    chk("ar_accept", 32'(bus.r0_ready), 1);
    tick();
    bus.r0_valid = 1'b0;
    #1;
    chk("ar_en_before", 32'(bus.fpu_enable), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_en",   32'(bus.fpu_enable), 0);
    chk("ar_busy", 32'(bus.busy),       0);
    chk("ar_rv",   32'(bus.rsp_valid),  0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ar_no_rsp", 32'(bus.rsp_valid | bus.busy), 0);
      tick();
    end
    bus.r0_valid = 1'b1; bus.r1_valid = 1'b1;
    #1;
    chk("ar_tie_r0", 32'(bus.r0_ready), 1);
    chk("ar_tie_r1", 32'(bus.r1_ready), 0);
    tick();
    bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
    drain("ar_drain");
    #1;
    chk("ar_count", 32'(bus.op_count), 1);

    // op_count wrap
    force dut.r_op_count = 16'hFFFF;
    #1;
    release dut.r_op_count;
    #1;
    chk("wrap_preload", 32'(bus.op_count), 'hFFFF);
    tick();
    bus.r1_valid = 1'b1; bus.r1_opcode = 4'hF; bus.rsp_ready = 1'b1;
    #1;
    chk("wrap_accept", 32'(bus.r1_ready), 1);
    tick();
    bus.r1_valid = 1'b0;
    #1;
    chk("wrap_rv", 32'(bus.rsp_valid), 1);
    tick(); #1;
    chk("wrap_zero", 32'(bus.op_count), 0);

    // Random traffic against the reference model
    do_reset();
    for (int r = 0; r < 2; r++) begin
      pend[r] = 1'b0; pa[r] = '0; pb[r] = '0; pop[r] = '0;
    end
    m_last = 1'b1; m_out = 1'b0; m_count = 16'd0; m_t_acc = 0;
    m_legal = 1'b0; m_id = 1'b0; m_err = 1'b0; m_res = '0; m_a = '0; m_b = '0; m_op = '0;
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r] = 1'b1;
          pa[r]   = {1'($urandom), 5'($urandom_range(12, 18)), 10'($urandom)};
          pb[r]   = {1'($urandom), 5'($urandom_range(12, 18)), 10'($urandom)};
          pop[r]  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(2, 15))
                                                : 4'($urandom_range(0, 1));
        end
      end
      bus.r0_valid = pend[0]; bus.r0_a = pa[0]; bus.r0_b = pb[0]; bus.r0_opcode = pop[0];
      bus.r1_valid = pend[1]; bus.r1_a = pa[1]; bus.r1_b = pb[1]; bus.r1_opcode = pop[1];
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      eg   = (pend[0] && pend[1]) ? ~m_last : pend[1];
      eacc = !m_out && pend[eg];
      age  = c - m_t_acc;
      erv  = m_out && (age >= (m_legal ? LAT + 1 : 1));
      een  = m_out && m_legal && age >= 1 && age <= LAT;
      chk("rnd_r0_ready", 32'(bus.r0_ready),   32'(eacc && !eg));
      chk("rnd_r1_ready", 32'(bus.r1_ready),   32'(eacc && eg));
      chk("rnd_rsp_valid", 32'(bus.rsp_valid), 32'(erv));
      chk("rnd_fpu_en",   32'(bus.fpu_enable), 32'(een));
      chk("rnd_busy",     32'(bus.busy),       32'(m_out));
      chk("rnd_op_count", 32'(bus.op_count),   32'(m_count));
      if (een) chk("rnd_fpu_ops", {bus.fpu_a, bus.fpu_b}, {m_a, m_b});
      else     chk("rnd_fpu_iso", {bus.fpu_a, bus.fpu_b}, 0);
      if (erv) begin
        chk("rnd_rsp_id",  32'(bus.rsp_id),     32'(m_id));
        chk("rnd_rsp_res", 32'(bus.rsp_result), 32'(m_res));
        chk("rnd_rsp_err", 32'(bus.rsp_err),    32'(m_err));
      end
      if (erv && bus.rsp_ready) begin
        m_out   = 1'b0;
        m_count = m_count + 16'd1;
      end else if (eacc) begin
        m_out   = 1'b1;
        m_t_acc = c;
        m_id    = eg;
        m_last  = eg;
        m_a     = pa[eg];
        m_b     = pb[eg];
        m_op    = pop[eg];
        m_legal = (int'(m_op) < NUM_OPS);
        m_err   = !m_legal;
        m_res   = m_legal ? fpu_model(m_a, m_b, m_op) : 16'h7E00;
        pend[eg] = 1'b0;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
